// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets and control bit positions for the MMIO window
package mmio_pkg;

  localparam logic [2:0] OFF_SW   = 3'd0;
  localparam logic [2:0] OFF_BTN  = 3'd1;
  localparam logic [2:0] OFF_EVT  = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_TMR  = 3'd4;
  localparam logic [2:0] OFF_TCTL = 3'd5;

  localparam int EN_BIT  = 0;
  localparam int OVF_BIT = 15;

  localparam int NUM_BTN = 3;
  localparam int NUM_SW  = 9;
  localparam int NUM_LED = 10;

endpackage

// File: rtl/mmio_responder_debouncer.sv
// rtl/mmio_responder_debouncer.sv - 2-flop synchronizer plus debounce counter for one button
// Level flips after DEBOUNCE_CYCLES consecutive clocks of disagreement; rise pulses on a 0->1 flip.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = din;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = ~level_q;
      cnt_d   = '0;
      rise    = ~level_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - MMIO window with switches, debounced buttons, event flags, LEDs and timer
// Answers reads one cycle after the address is sampled, matching the program memory latency.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 6,
  parameter int                    DATA_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE       = 6'h38,
  parameter int                    DEBOUNCE_CYCLES = 500_000,
  parameter int                    PRESCALE        = 50_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  hit,
  input  logic [NUM_BTN-1:0]    btn,
  input  logic [NUM_SW-1:0]     sw,
  output logic [NUM_LED-1:0]    led
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic                  sel, rd_en, wr_en;
  logic [2:0]            off;
  logic [DATA_WIDTH-1:0] rdata;

  logic [NUM_SW-1:0]     sw_s1_q, sw_s1_d;
  logic [NUM_SW-1:0]     sw_s2_q, sw_s2_d;
  logic [NUM_BTN-1:0]    btn_n, btn_lvl, btn_rise;
  logic [NUM_BTN-1:0]    flags_q, flags_d, flags_clr;
  logic [NUM_LED-1:0]    led_q, led_d;
  logic [DATA_WIDTH-1:0] timer_q, timer_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic                  en_q, en_d;
  logic                  ovf_q, ovf_d, ovf_set, tick;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  hit_q, hit_d;

  assign btn_n = ~btn;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn_n[i]),
      .level(btn_lvl[i]),
      .rise (btn_rise[i])
    );
  end

  always_comb begin
    sel   = (addr[ADDR_WIDTH-1:3] == MMIO_BASE[ADDR_WIDTH-1:3]);
    off   = addr[2:0];
    rd_en = sel & ~we;
    wr_en = sel & we;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_SW:   rdata[NUM_SW-1:0]  = sw_s2_q;
      OFF_BTN:  rdata[NUM_BTN-1:0] = btn_lvl;
      OFF_EVT:  rdata[NUM_BTN-1:0] = flags_q;
      OFF_LED:  rdata[NUM_LED-1:0] = led_q;
      OFF_TMR:  rdata              = timer_q;
      OFF_TCTL: begin
        rdata[OVF_BIT] = ovf_q;
        rdata[EN_BIT]  = en_q;
      end
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    sw_s1_d = sw;
    sw_s2_d = sw_s1_q;
    out_d   = rd_en ? rdata : '0;
    hit_d   = sel;
  end

  // A fresh rise is OR-ed in after the clear so simultaneous set beats clear.
  always_comb begin
    flags_clr = '0;
    if (rd_en && off == OFF_EVT) begin
      flags_clr = '1;
    end else if (wr_en && off == OFF_EVT) begin
      flags_clr = data[NUM_BTN-1:0];
    end
    flags_d = (flags_q & ~flags_clr) | btn_rise;
  end

  always_comb begin
    led_d = led_q;
    if (wr_en && off == OFF_LED) begin
      led_d = data[NUM_LED-1:0];
    end
  end

  // A TMR write overrides a same-cycle increment, including its overflow.
  always_comb begin
    tick    = en_q && (pre_q == PRE_MAX);
    pre_d   = pre_q;
    timer_d = timer_q;
    ovf_set = 1'b0;
    if (en_q) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        timer_d = timer_q + DATA_WIDTH'(1);
        ovf_set = &timer_q;
      end
    end
    if (wr_en && off == OFF_TMR) begin
      timer_d = data;
      pre_d   = '0;
      ovf_set = 1'b0;
    end
  end

  always_comb begin
    en_d  = en_q;
    ovf_d = ovf_q;
    if (wr_en && off == OFF_TCTL) begin
      en_d = data[EN_BIT];
      if (data[OVF_BIT]) begin
        ovf_d = 1'b0;
      end
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      flags_q <= '0;
      led_q   <= '0;
      timer_q <= '0;
      pre_q   <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      flags_q <= flags_d;
      led_q   <= led_d;
      timer_q <= timer_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
      hit_q   <= hit_d;
    end
  end

  assign out = out_q;
  assign hit = hit_q;
  assign led = led_q;

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the CPU data bus (we, addr, data, out), in parallel with the program memory.
- The CPU acts as initiator. This block answers accesses in a fixed address window, with the same 1-cycle registered read latency as the memory.
- It exposes switches, debounced buttons with sticky edge flags, an LED register and a prescaled timer.
- Top level selects `out` over the memory output when `hit` is high.

Parameters:
- ADDR_WIDTH, 6, CPU address width.
- DATA_WIDTH, 16, bus data width. Must be ≥16.
- MMIO_BASE, 6'h38, base of the 8-word window; low 3 bits must be 0.
- DEBOUNCE_CYCLES, 500_000, number of consecutive stable clocks before the debounced button level changes.
- PRESCALE, 50_000, clocks per timer increment. Must be ≥1.

Ports:
- clk, input, 1, system clock (same clock as the memory and CPU).
- rst_n, input, 1, asynchronous active-low reset.
- we, input, 1, CPU write enable.
- addr, input, ADDR_WIDTH, CPU address.
- data, input, DATA_WIDTH, CPU write data.
- out, output, DATA_WIDTH, registered read data.
- hit, output, 1, registered; high when the previous-cycle address fell in the window.
- btn, input, 3, raw push-buttons, active-low.
- sw, input, 9, raw slide switches.
- led, output, 10, LED register.

Behaviour:
- **Reset (async, rst_n=0):**
  - out=0, hit=0, led=0.
  - Timer=0, enable=0, overflow=0, event flags=0.
  - Debounced levels=0 (released), synchronizers=0, debounce and prescale counters=0.
- **Input synchronization:** btn is inverted, then btn and sw each pass through a 2-flop synchronizer. Software sees sw with 2-cycle latency.
- **Debounce (per button):**
  - Counter resets whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - A 0→1 transition of the debounced level sets that button's event flag.
- **Window decode:** sel = (addr[ADDR_WIDTH-1:3] == MMIO_BASE[ADDR_WIDTH-1:3]); offset = addr[2:0]. Sampled every rising edge.
- **Read (we=0, sel=1):**
  - Next cycle: hit=1 and out=register value.
  - When sel=0: hit=0 and out=0.
- **Read side effects:** a sampled read of offset 2 clears the event flags after returning them. A CPU holding the address for N cycles sees the flags once, then 0.
- **Write (we=1, sel=1):** takes effect at the same edge. hit=1 next cycle, out=0.
- **Register map (offset: read / write):**
  - 0 SW: {0, sw_sync[8:0]} / ignored.
  - 1 BTN: {0, debounced[2:0]} / ignored.
  - 2 EVT: {0, flags[2:0]}, read clears / write-1-to-clear data[2:0].
  - 3 LED: {0, led} / led ← data[9:0].
  - 4 TMR: timer value / timer ← data; prescale counter cleared.
  - 5 TCTL: {overflow, 0, enable} (bit15, bit0) / enable ← data[0]; data[15]=1 clears overflow.
  - 6, 7: read 0 / ignored.
- **Timer:**
  - When enable=1, the prescale counter counts 0..PRESCALE-1. At wrap the timer increments modulo 2^DATA_WIDTH.
  - Timer wrap from all-ones to 0 sets overflow.
  - When enable=0, both counters hold.
- **Simultaneous events (set wins over clear):**
  - Event-flag set in the same cycle as a read-clear or W1C: flag ends set.
  - Overflow set in the same cycle as a TCTL clear: overflow ends set.
  - Write to TMR in the same cycle as an increment: the write wins.
- **Reset mid-operation:** all state is immediately lost. A pending read yields hit=0, out=0.

Decomposition:
- Shared package `mmio_pkg`: offset constants OFF_SW=0, OFF_BTN=1, OFF_EVT=2, OFF_LED=3, OFF_TMR=4, OFF_TCTL=5; TCTL bit positions EN_BIT=0, OVF_BIT=15.
- One sub-module `debouncer` (1-bit synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES, outputs level and rise pulse), instantiated 3×.

Test Plan:
1. Reset: after rst_n deassert, with sw=9'h1A5 held 3 cycles, read addr 0x38 → hit=1 and out=16'h01A5 one cycle later. Read of 0x30 → hit=0, out=0.
2. Debounce (DEBOUNCE_CYCLES=4):
   - btn[1] pulled low for 3 cycles, then released → BTN reads 0 and EVT reads 0.
   - btn[1] held low for 10 cycles → BTN=16'h0002.
   - EVT reads 16'h0002 once; an immediately repeated read returns 0.
3. LED: write 16'hFFFF to 0x3B → led=10'h3FF after the edge. Read 0x3B → 16'h03FF.
4. Timer (PRESCALE=2):
   - Write TMR=16'hFFFE, then TCTL=1. After 4 clocks TMR=16'h0000.
   - TCTL reads 16'h8001. Write 16'h8001 to TCTL → reads 16'h0001.
5. Collisions:
   - A debounced rise of btn[0] in the same cycle as a W1C write of 1 to EVT → EVT reads 1.
   - Timer wrap in the same cycle as a TCTL clear → overflow still set.
6. Reset mid-op: assert rst_n=0 during a held read of 0x3B with led=10'h155 → out=0, hit=0, led=0 immediately, without waiting for a clock edge.
